// File: rtl/double_to_long_small.sv
// double_to_long_small: converts an IEEE-754 binary64 operand to a signed 64-bit integer,
// truncating toward zero and saturating on overflow. The operand is taken in and the result
// handed out over ready/continue handshakes. Only one operand is processed at a time, and
// alignment uses a one-bit-per-cycle serial shifter.
module double_to_long_small (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] double_val,
  input  logic        double_cont,
  input  logic        long_cont,
  output logic [63:0] long_val,
  output logic        double_ready,
  output logic        long_ready
);

  typedef enum logic [2:0] {
    StGetin,
    StUnpack,
    StAlign,
    StSign,
    StPutout
  } state_e;

  state_e      state_q, state_d;
  logic        double_ready_q, double_ready_d;
  logic        long_ready_q, long_ready_d;
  logic [63:0] long_val_q, long_val_d;

  logic [63:0] operand_q, operand_d;
  logic [63:0] mag_q, mag_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;

  logic        op_sign;
  logic [10:0] op_exp;
  logic [51:0] op_frac;
  logic [63:0] signed_mag;

  assign op_sign    = operand_q[63];
  assign op_exp     = operand_q[62:52];
  assign op_frac    = operand_q[51:0];
  assign signed_mag = op_sign ? (~mag_q + 64'd1) : mag_q;

  assign long_val     = long_val_q;
  assign double_ready = double_ready_q;
  assign long_ready   = long_ready_q;

  // Next-state and datapath decode; every target holds its value unless a state changes it.
  always_comb begin
    state_d        = state_q;
    double_ready_d = double_ready_q;
    long_ready_d   = long_ready_q;
    long_val_d     = long_val_q;
    operand_d      = operand_q;
    mag_d          = mag_q;
    cnt_d          = cnt_q;
    result_d       = result_q;

    case (state_q)
      StGetin: begin
        double_ready_d = 1'b1;
        if (double_ready_q && double_cont) begin
          operand_d      = double_val;
          double_ready_d = 1'b0;
          state_d        = StUnpack;
        end
      end

      StUnpack: begin
        if (op_exp == 11'h7FF && op_frac != 52'd0) begin
          result_d = 64'd0;
          state_d  = StPutout;
        end else if (op_exp >= 11'd1086) begin
          // Covers infinity as well; -2^63 is exact here, not a clipped value.
          result_d = op_sign ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
          state_d  = StPutout;
        end else if (op_exp < 11'd1023) begin
          result_d = 64'd0;
          state_d  = StPutout;
        end else begin
          mag_d   = {1'b1, op_frac, 11'b0};
          // e = exp - 1023 lies in 0..62; since 1023 = 63 mod 64, e equals exp[5:0] + 1.
          cnt_d   = op_exp[5:0] + 6'd1;
          state_d = StAlign;
        end
      end

      StAlign: begin
        if (cnt_q != 6'd63) begin
          mag_d = {1'b0, mag_q[63:1]};
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d = StSign;
        end
      end

      StSign: begin
        // Presents the result directly so the normal path saves the PUTOUT load cycle.
        result_d     = signed_mag;
        long_val_d   = signed_mag;
        long_ready_d = 1'b1;
        state_d      = StPutout;
      end

      StPutout: begin
        long_val_d   = result_q;
        long_ready_d = 1'b1;
        if (long_ready_q && long_cont) begin
          long_ready_d = 1'b0;
          state_d      = StGetin;
        end
      end

      default: state_d = StGetin;
    endcase
  end

  // Control state and visible outputs, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StGetin;
      double_ready_q <= 1'b0;
      long_ready_q   <= 1'b0;
      long_val_q     <= 64'd0;
    end else begin
      state_q        <= state_d;
      double_ready_q <= double_ready_d;
      long_ready_q   <= long_ready_d;
      long_val_q     <= long_val_d;
    end
  end

  // Datapath registers; every value is written before it is read, so they have no reset.
  always_ff @(posedge clk) begin
    operand_q <= operand_d;
    mag_q     <= mag_d;
    cnt_q     <= cnt_d;
    result_q  <= result_d;
  end

endmodule

// File: tb/tb_double_to_long_small.sv
// Bench for double_to_long_small: an arithmetic reference model tracked per cycle and compared
// on every falling edge, plus hand-computed results and latencies for directed operands.
module tb_double_to_long_small;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] double_val = 64'd0;
  logic        double_cont = 1'b0;
  logic        long_cont = 1'b1;
  logic [63:0] long_val;
  logic        double_ready;
  logic        long_ready;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  double_to_long_small dut (
    .clk         (clk),
    .rst         (rst),
    .double_val  (double_val),
    .double_cont (double_cont),
    .long_cont   (long_cont),
    .long_val    (long_val),
    .double_ready(double_ready),
    .long_ready  (long_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference conversion from the rules: NaN -> 0, |x| >= 2^63 -> saturate, |x| < 1 -> 0,
  // otherwise the integer part of the value with the operand's sign.
  function automatic logic [63:0] conv(input logic [63:0] v);
    int          e;
    logic [63:0] mant;
    logic [63:0] mag;
    e = int'(v[62:52]) - 1023;
    if (v[62:52] == 11'h7FF && v[51:0] != 52'd0) return 64'd0;
    if (e >= 63) return v[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    if (e < 0) return 64'd0;
    mant = {11'd0, 1'b1, v[51:0]};
    mag  = (e >= 52) ? (mant << (e - 52)) : (mant >> (52 - e));
    return v[63] ? (64'd0 - mag) : mag;
  endfunction

  function automatic int lat_of(input logic [63:0] v);
    int e;
    e = int'(v[62:52]) - 1023;
    if (v[62:52] == 11'h7FF) return 2;
    if (e >= 63 || e < 0) return 2;
    return 66 - e;
  endfunction

  // Cycle model: idle (offering), busy (counting down the latency), output (waiting for cont).
  int          m_phase = 0;
  int          m_left = 0;
  logic        m_dready = 1'b0;
  logic        m_lready = 1'b0;
  logic [63:0] m_lval = 64'd0;
  logic [63:0] m_res = 64'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_dready <= 1'b0;
      m_lready <= 1'b0;
      m_lval   <= 64'd0;
    end else begin
      case (m_phase)
        0: begin
          if (m_dready && double_cont) begin
            m_dready <= 1'b0;
            m_left   <= lat_of(double_val);
            m_res    <= conv(double_val);
            m_phase  <= 1;
          end else begin
            m_dready <= 1'b1;
          end
        end
        1: begin
          if (m_left == 1) begin
            m_lready <= 1'b1;
            m_lval   <= m_res;
            m_phase  <= 2;
          end else begin
            m_left <= m_left - 1;
          end
        end
        default: begin
          if (long_cont) begin
            m_lready <= 1'b0;
            m_phase  <= 0;
          end
        end
      endcase
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_double_ready", {63'd0, double_ready}, {63'd0, m_dready});
      chk("cyc_long_ready", {63'd0, long_ready}, {63'd0, m_lready});
      chk("cyc_long_val", long_val, m_lval);
    end
  end

  logic [63:0] tv_in [12] = '{
    64'h3FF0_0000_0000_0000, 64'hC006_0000_0000_0000, 64'h4330_0000_0000_0000,
    64'h43E1_58E4_6091_3D00, 64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000,
    64'h3FE0_0000_0000_0000, 64'h8000_0000_0000_0000, 64'hC3E0_0000_0000_0000,
    64'h43DF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'hC00C_0000_0000_0000
  };
  logic [63:0] tv_out [12] = '{
    64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0010_0000_0000_0000,
    64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000,
    64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000,
    64'h7FFF_FFFF_FFFF_FC00, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD
  };
  int tv_lat [12] = '{66, 65, 14, 2, 2, 2, 2, 2, 2, 4, 2, 65};

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!double_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!double_ready) chk("double_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [63:0] v, input logic [63:0] want, input int want_lat,
                      input bit hold);
    int n;
    wait_ready();
    long_cont   = !hold;
    double_val  = v;
    double_cont = 1'b1;
    @(posedge clk);
    #1 double_cont = 1'b0;
    n = 0;
    while (!long_ready && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 64'(n), 64'(want_lat));
    chk("result", long_val, want);
    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        double_cont = ~double_cont;
        chk("hold_long_ready", {63'd0, long_ready}, 64'd1);
        chk("hold_long_val", long_val, want);
        chk("hold_double_ready", {63'd0, double_ready}, 64'd0);
      end
      double_cont = 1'b0;
      long_cont   = 1'b1;
    end
    @(posedge clk);
    #1 chk("handshake_clears", {63'd0, long_ready}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit rose;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_long_val", long_val, 64'd0);
    chk("reset_double_ready", {63'd0, double_ready}, 64'd0);
    chk("reset_long_ready", {63'd0, long_ready}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_reset", {63'd0, double_ready}, 64'd1);

    for (int i = 0; i < 12; i++) begin
      chk("model_pin", conv(tv_in[i]), tv_out[i]);
      send(tv_in[i], tv_out[i], tv_lat[i], 1'b0);
    end

    // Output held back while double_cont toggles.
    send(64'hC006_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b1);

    // Reset in the middle of alignment of 1.0.
    wait_ready();
    double_val  = 64'h3FF0_0000_0000_0000;
    double_cont = 1'b1;
    @(posedge clk);
    #1 double_cont = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midreset_long_val", long_val, 64'd0);
    chk("midreset_long_ready", {63'd0, long_ready}, 64'd0);
    chk("midreset_double_ready", {63'd0, double_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rose = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1 if (long_ready) rose = 1'b1;
    end
    chk("abandoned_never_ready", {63'd0, rose}, 64'd0);
    send(64'h4330_0000_0000_0000, 64'h0010_0000_0000_0000, 14, 1'b0);
    send(64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 66, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/double_to_long_small.md
DOUBLE_TO_LONG_SMALL -- requirements
Module: double_to_long_small

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 64 bits.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 double_val  input  64  IEEE-754 binary64 operand: sign [63], biased exponent [62:52], fraction [51:0].
REQ-005 double_cont  input  1  upstream offers double_val; transfer occurs when double_cont and double_ready are both high at a clock edge.
REQ-006 long_cont  input  1  downstream accepts long_val; transfer occurs when long_cont and long_ready are both high at a clock edge.
REQ-007 long_val  output  64  signed two's-complement integer result, registered.
REQ-008 double_ready  output  1  block can accept an operand, registered.
REQ-009 long_ready  output  1  long_val holds a valid result, registered.

Function
REQ-010 The FSM SHALL have states GETIN, UNPACK, ALIGN, SIGN and PUTOUT, and SHALL process one operand at a time (no overlap).
REQ-011 In GETIN, double_ready SHALL be driven to 1 each cycle; on an edge with double_ready=1 and double_cont=1 it SHALL capture double_val, clear double_ready and go to UNPACK; double_ready is therefore first high one cycle after GETIN is entered.
REQ-012 In UNPACK, with unbiased exponent e = exp-1023, the block SHALL take exactly one of the following actions.
REQ-013 UNPACK, exp=0x7FF and fraction≠0 (NaN): result SHALL be 0, then PUTOUT.
REQ-014 UNPACK, e≥63, including ±infinity: result SHALL saturate to 0x7FFF_FFFF_FFFF_FFFF (sign 0) or 0x8000_0000_0000_0000 (sign 1), then PUTOUT; -2^63 is produced exactly by this path.
REQ-015 UNPACK, e<0, including ±0 and subnormals: result SHALL be 0 (sign discarded), then PUTOUT.
REQ-016 UNPACK, otherwise: magnitude register SHALL be loaded with {1, fraction, 11'b0} and exponent counter with e, then ALIGN.
REQ-017 In ALIGN, each cycle with counter≠63 SHALL shift the magnitude right one bit (zero fill) and increment the counter; when counter=63 it SHALL go to SIGN without shifting.
REQ-018 In SIGN, result SHALL be the two's complement of the magnitude if sign=1, else the magnitude, then PUTOUT.
REQ-019 Fractional bits SHALL be discarded, giving rounding toward zero (e.g. 2.75→2, -2.75→-2); no rounding increment exists.
REQ-020 In PUTOUT, long_val SHALL be loaded with the result and long_ready driven to 1 each cycle; on an edge with long_ready=1 and long_cont=1, long_ready SHALL clear and the FSM return to GETIN.
REQ-021 long_val SHALL hold its last value after the output handshake until the next PUTOUT.
REQ-022 Latency, counted in clock edges after the capture edge until long_ready is first high: 66-e for the normal path (14 at e=52, 66 at e=0).
REQ-023 Latency on the special paths (NaN, saturate, zero) SHALL be 2.
REQ-024 If long_cont is held high, the return to GETIN SHALL occur on the edge after long_ready first rises; if it is held low, PUTOUT SHALL persist indefinitely with long_val stable.
REQ-025 double_cont SHALL be ignored outside GETIN, and long_cont SHALL be ignored outside PUTOUT.

Reset
REQ-026 While rst=1, regardless of clk, state SHALL be GETIN, long_val 0, double_ready 0 and long_ready 0.
REQ-027 Assertion of rst in any state, including mid-ALIGN, SHALL abandon the operand with no result ever presented.
REQ-028 After rst deasserts, double_ready SHALL rise on the first clock edge.
REQ-029 Internal datapath registers (magnitude, counter, sign) need no reset value.

Verification
REQ-030 0x3FF0_0000_0000_0000 (1.0), long_cont=1 -> long_val=0x0000_0000_0000_0001, long_ready high exactly 66 edges after capture.
REQ-031 0xC006_0000_0000_0000 (-2.75) -> 0xFFFF_FFFF_FFFF_FFFE; 0x4330_0000_0000_0000 (2^52) -> 0x0010_0000_0000_0000 with latency 14.
REQ-032 0x43E1_58E4_6091_3D00 (1e19) -> 0x7FFF_FFFF_FFFF_FFFF; 0xFFF0_0000_0000_0000 (-inf) -> 0x8000_0000_0000_0000; 0x7FF8_0000_0000_0000 (NaN) -> 0; each with latency 2.
REQ-033 0x3FE0_0000_0000_0000 (0.5) and 0x8000_0000_0000_0000 (-0) -> 0x0000_0000_0000_0000.
REQ-034 Hold long_cont=0 for 20 cycles in PUTOUT -> long_ready and long_val stable, double_ready 0; double_cont pulses ignored until the output handshake completes.
REQ-035 Assert rst 10 cycles into ALIGN for 1.0 -> outputs zero immediately, long_ready never rises for that operand, next operand converts correctly.
